countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 122 ++++++++++++
 tb/tb_countdown_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: keypad digits shift in from the right, a 1 Hz tick
// counts down while enabled, and the FSM reports counting/done.
module countdown_timer #(
  parameter int SYNC_FF = 2  // synchronizer depth, legal 2..4
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] data,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       en,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       counting,
  output logic       done,
  output logic       zero
);

  typedef enum logic [1:0] {S_IDLE, S_COUNTING, S_DONE} state_t;

  state_t             r_state;
  logic [SYNC_FF-1:0] r_loadn_sync;
  logic [SYNC_FF-1:0] r_tick_sync;
  logic               r_loadn_prev;
  logic               r_tick_prev;
  logic [3:0]         r_mt, r_mo, r_st, r_so;

  logic       w_load_evt, w_tick_evt, w_key_ok;
  logic [3:0] w_mt_dec, w_mo_dec, w_st_dec, w_so_dec;
  logic       w_dec_zero;

  // Reset values match the idle input levels so release never fakes an edge.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_loadn_sync <= '1;
      r_loadn_prev <= 1'b1;
      r_tick_sync  <= '0;
      r_tick_prev  <= 1'b0;
    end else begin
      r_loadn_sync <= {r_loadn_sync[SYNC_FF-2:0], loadn};
      r_loadn_prev <= r_loadn_sync[SYNC_FF-1];
      r_tick_sync  <= {r_tick_sync[SYNC_FF-2:0], pgt_1hz};
      r_tick_prev  <= r_tick_sync[SYNC_FF-1];
    end
  end

  assign w_load_evt = r_loadn_prev & ~r_loadn_sync[SYNC_FF-1];
  assign w_tick_evt = ~r_tick_prev & r_tick_sync[SYNC_FF-1];
  assign w_key_ok   = w_load_evt && (data <= 4'd9);

  // sec_tens borrows to 5 (minutes have 60 s); other digits borrow to 9.
  always_comb begin
    w_so_dec = r_so - 4'd1;
    w_st_dec = r_st;
    w_mo_dec = r_mo;
    w_mt_dec = r_mt;
    if (r_so == 4'd0) begin
      w_so_dec = 4'd9;
      if (r_st == 4'd0) begin
        w_st_dec = 4'd5;
        if (r_mo == 4'd0) begin
          w_mo_dec = 4'd9;
          w_mt_dec = r_mt - 4'd1;
        end else begin
          w_mo_dec = r_mo - 4'd1;
        end
      end else begin
        w_st_dec = r_st - 4'd1;
      end
    end
  end

  assign w_dec_zero = ({w_mt_dec, w_mo_dec, w_st_dec, w_so_dec} == 16'h0000);

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_state <= S_IDLE;
      r_mt    <= 4'd0;
      r_mo    <= 4'd0;
      r_st    <= 4'd0;
      r_so    <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_key_ok) begin
            {r_mt, r_mo, r_st, r_so} <= {r_mo, r_st, r_so, data};
          end else if (en && !zero) begin
            r_state <= S_COUNTING;
          end
        end
        S_COUNTING: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (w_tick_evt) begin
            {r_mt, r_mo, r_st, r_so} <= {w_mt_dec, w_mo_dec, w_st_dec, w_so_dec};
            if (w_dec_zero) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_key_ok) begin
            {r_mt, r_mo, r_st, r_so} <= {r_mo, r_st, r_so, data};
            r_state <= S_IDLE;
          end else if (!en) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign min_tens = r_mt;
  assign min_ones = r_mo;
  assign sec_tens = r_st;
  assign sec_ones = r_so;
  assign counting = (r_state == S_COUNTING);
  assign done     = (r_state == S_DONE);
  assign zero     = ({r_mt, r_mo, r_st, r_so} == 16'h0000);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: stimulus queues expected snapshots,
// a monitor pops and compares them against the outputs on each falling edge.
module tb_countdown_timer;

  localparam int SYNC_FF = 2;
  localparam int HOLD    = SYNC_FF + 2;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic [3:0] data = 4'd0;
  logic       loadn = 1'b1;
  logic       pgt_1hz = 1'b0;
  logic       en = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       counting, done, zero;

  countdown_timer #(.SYNC_FF(SYNC_FF)) dut (
    .clk(clk), .clearn(clearn), .data(data), .loadn(loadn), .pgt_1hz(pgt_1hz),
    .en(en), .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .counting(counting), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [18:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: output bundle is {MM:SS, counting, done, zero}.
  initial begin
    sb_entry_t   e;
    logic [18:0] got;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = {min_tens, min_ones, sec_tens, sec_ones, counting, done, zero};
        n_checks++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h:%h c=%b d=%b z=%b, expected %h:%h c=%b d=%b z=%b",
                   e.name, got[18:11], got[10:3], got[2], got[1], got[0],
                   e.exp[18:11], e.exp[10:3], e.exp[2], e.exp[1], e.exp[0]);
        end else begin
          $display("ok   %s: %h:%h c=%b d=%b z=%b", e.name, got[18:11], got[10:3],
                   got[2], got[1], got[0]);
        end
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] d, input logic c,
                     input logic dn, input logic z);
    sb_entry_t e;
    e.name = nm;
    e.exp  = {d, c, dn, z};
    sb_q.push_back(e);
    wait_n(1);
  endtask

  task automatic key(input logic [3:0] d);
    data  = d;
    loadn = 1'b0;
    wait_n(HOLD);
    loadn = 1'b1;
    wait_n(HOLD);
  endtask

  task automatic tick();
    pgt_1hz = 1'b1;
    wait_n(HOLD);
    pgt_1hz = 1'b0;
    wait_n(HOLD);
  endtask

  task automatic reset_pulse();
    clearn = 1'b0;
    wait_n(1);
    clearn = 1'b1;
    wait_n(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_n(1);
    chk("reset", 16'h0000, 1'b0, 1'b0, 1'b1);
    clearn = 1'b1;
    wait_n(1);

    key(4'd1); chk("key1", 16'h0001, 1'b0, 1'b0, 1'b0);
    key(4'd3); chk("key3", 16'h0013, 1'b0, 1'b0, 1'b0);
    key(4'd0); chk("key0", 16'h0130, 1'b0, 1'b0, 1'b0);

    en = 1'b1;
    wait_n(1);
    chk("start", 16'h0130, 1'b1, 1'b0, 1'b0);
    tick(); chk("tick1", 16'h0129, 1'b1, 1'b0, 1'b0);
    tick(); chk("tick2", 16'h0128, 1'b1, 1'b0, 1'b0);
    tick(); chk("tick3", 16'h0127, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 27; i++) tick();
    chk("at_0100", 16'h0100, 1'b1, 1'b0, 1'b0);
    tick(); chk("borrow_min", 16'h0059, 1'b1, 1'b0, 1'b0);

    en = 1'b0;
    wait_n(1);
    chk("pause", 16'h0059, 1'b0, 1'b0, 1'b0);
    key(4'd0); key(4'd0); key(4'd0); key(4'd2);
    chk("preset_0002", 16'h0002, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    wait_n(1);
    tick(); chk("to_0001", 16'h0001, 1'b1, 1'b0, 1'b0);
    tick(); chk("to_done", 16'h0000, 1'b0, 1'b1, 1'b1);
    wait_n(3);
    chk("done_holds", 16'h0000, 1'b0, 1'b1, 1'b1);
    en = 1'b0;
    wait_n(1);
    chk("done_to_idle", 16'h0000, 1'b0, 1'b0, 1'b1);
    en = 1'b1;
    wait_n(2);
    chk("zero_no_start", 16'h0000, 1'b0, 1'b0, 1'b1);

    en = 1'b0;
    key(4'd1);
    en = 1'b1;
    wait_n(1);
    tick(); chk("done_again", 16'h0000, 1'b0, 1'b1, 1'b1);
    // Key 5 lands on the third rising edge after loadn falls (SYNC_FF=2).
    data  = 4'd5;
    loadn = 1'b0;
    repeat (SYNC_FF + 1) @(posedge clk);
    sb_q.push_back('{name: "key5_in_done", exp: {16'h0005, 1'b0, 1'b0, 1'b0}});
    wait_n(1);
    en = 1'b0;
    loadn = 1'b1;
    wait_n(HOLD);
    chk("key5_idle", 16'h0005, 1'b0, 1'b0, 1'b0);

    reset_pulse();
    key(4'd4); key(4'd5);
    en = 1'b1;
    wait_n(1);
    chk("run_0045", 16'h0045, 1'b1, 1'b0, 1'b0);
    key(4'd7); chk("key_in_counting", 16'h0045, 1'b1, 1'b0, 1'b0);
    // Tick event and en=0 meet on the same edge.
    pgt_1hz = 1'b1;
    repeat (SYNC_FF) @(posedge clk);
    @(negedge clk); #1;
    en = 1'b0;
    @(posedge clk);
    sb_q.push_back('{name: "pause_with_tick", exp: {16'h0045, 1'b0, 1'b0, 1'b0}});
    wait_n(1);
    pgt_1hz = 1'b0;
    wait_n(HOLD);
    key(4'd12); chk("key12_ignored", 16'h0045, 1'b0, 1'b0, 1'b0);

    en = 1'b1;
    wait_n(1);
    tick(); chk("count_0044", 16'h0044, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    clearn = 1'b0;
    sb_q.push_back('{name: "async_clear", exp: {16'h0000, 1'b0, 1'b0, 1'b1}});
    wait_n(1);
    en = 1'b0;
    clearn = 1'b1;
    wait_n(1);

    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    chk("preset_9999", 16'h9999, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    wait_n(1);
    tick(); chk("9999_tick", 16'h9998, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    wait_n(1);
    reset_pulse();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    chk("preset_1000", 16'h1000, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    wait_n(1);
    tick(); chk("1000_tick", 16'h0959, 1'b1, 1'b0, 1'b0);

    wait_n(2);
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
